// File: rtl/cpu_pkg.sv
// Shared CPU constants and types: control-state width, the ALU-form state mask
// and the GPR index type used by the register select logic.
package cpu_pkg;

  localparam int STATE_W   = 40;
  localparam int NGPR_DEF  = 16;
  localparam int GPR_SEL_W = $clog2(NGPR_DEF);

  // One-hot states 26, 28, 30, 32, 34 and 36 take their operands from the ALU-form fields
  localparam logic [STATE_W-1:0] STATE_AL_MASK = 40'h15_5400_0000;

  typedef logic [GPR_SEL_W-1:0] gpr_idx_t;

endpackage

// File: rtl/gpr_scoreboard.sv
// Outstanding-write scoreboard: one pending bit per GPR, set on issue, cleared
// on writeback (set wins on collision), with a registered population count.
module gpr_scoreboard
  import cpu_pkg::*;
#(
  parameter int NGPR     = 16,
  parameter int SEL_W    = $clog2(NGPR),
  parameter bit ZERO_REG = 1'b0,
  parameter int CNT_W    = $clog2(NGPR+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue,
  input  logic [SEL_W-1:0] dest,
  input  logic             wb_valid,
  input  logic [SEL_W-1:0] wb_reg,
  output logic [NGPR-1:0]  pending,
  output logic [CNT_W-1:0] pending_cnt,
  output logic [NGPR-1:0]  next_pending
);

  // R0 is hard-wired when ZERO_REG is set, so it can never become outstanding
  localparam logic [NGPR-1:0] KEEP_MASK = ZERO_REG ? ~NGPR'(1) : {NGPR{1'b1}};

  logic [NGPR-1:0]  set_v;
  logic [NGPR-1:0]  clr_v;
  logic [NGPR-1:0]  pending_d;
  logic [NGPR-1:0]  pending_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  for (genvar gi = 0; gi < NGPR; gi++) begin : g_dec
    assign set_v[gi] = issue    && (dest   == SEL_W'(gi));
    assign clr_v[gi] = wb_valid && (wb_reg == SEL_W'(gi));
  end

  assign pending_d = ((pending_q & ~clr_v) | set_v) & KEEP_MASK;

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NGPR; i++) begin
      cnt_d = cnt_d + CNT_W'(pending_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pending      = pending_q;
  assign pending_cnt  = cnt_q;
  assign next_pending = pending_d;

endmodule

// File: rtl/gpr_sel_unit.sv
// GPR read-port select unit: picks default or ALU-form operand fields from the
// one-hot control state, registers the selects and flags RAW hazards against the scoreboard.
module gpr_sel_unit
  import cpu_pkg::*;
#(
  parameter int                 NGPR     = 16,
  parameter int                 SEL_W    = $clog2(NGPR),
  parameter int                 NPORT    = 2,
  parameter int                 STATE_W  = cpu_pkg::STATE_W,
  parameter logic [STATE_W-1:0] AL_MASK  = cpu_pkg::STATE_AL_MASK,
  parameter bit                 ZERO_REG = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [STATE_W-1:0]         state,
  input  logic [NPORT*SEL_W-1:0]     rop_def,
  input  logic [NPORT*SEL_W-1:0]     rop_al,
  input  logic                       hold,
  input  logic                       issue,
  input  logic [SEL_W-1:0]           dest,
  input  logic                       wb_valid,
  input  logic [SEL_W-1:0]           wb_reg,
  output logic [NPORT*SEL_W-1:0]     gpr_sel,
  output logic                       sel_valid,
  output logic                       hazard,
  output logic                       state_err,
  output logic [NGPR-1:0]            pending,
  output logic [$clog2(NGPR+1)-1:0]  pending_cnt
);

  logic                   onehot;
  logic                   use_al;
  logic [NPORT*SEL_W-1:0] sel_mux;
  logic [NPORT*SEL_W-1:0] sel_d;
  logic [NPORT*SEL_W-1:0] sel_q;
  logic                   valid_d;
  logic                   valid_q;
  logic                   err_d;
  logic                   err_q;
  logic [NPORT-1:0]       port_haz;
  logic                   hazard_d;
  logic                   hazard_q;
  logic [NGPR-1:0]        next_pending;

  assign onehot = (state != '0) && ((state & (state - STATE_W'(1))) == '0);
  // An illegal state falls back to the default fields even if it touches ALU-form bits
  assign use_al = onehot && (|(state & AL_MASK));

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
    assign sel_mux[gi*SEL_W +: SEL_W] = use_al ? rop_al[gi*SEL_W +: SEL_W]
                                               : rop_def[gi*SEL_W +: SEL_W];
    // Looked up against the post-hold select, so a held stall still sees writebacks land
    assign port_haz[gi] = next_pending[sel_d[gi*SEL_W +: SEL_W]];
  end

  assign sel_d    = hold ? sel_q   : sel_mux;
  assign valid_d  = hold ? valid_q : onehot;
  assign err_d    = hold ? err_q   : !onehot;
  assign hazard_d = |port_haz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      hazard_q <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      hazard_q <= hazard_d;
    end
  end

  gpr_scoreboard #(
    .NGPR     (NGPR),
    .SEL_W    (SEL_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue        (issue),
    .dest         (dest),
    .wb_valid     (wb_valid),
    .wb_reg       (wb_reg),
    .pending      (pending),
    .pending_cnt  (pending_cnt),
    .next_pending (next_pending)
  );

  assign gpr_sel   = sel_q;
  assign sel_valid = valid_q;
  assign state_err = err_q;
  assign hazard    = hazard_q;

endmodule

// File: tb/tb_gpr_sel_unit.sv
// Bench for gpr_sel_unit: two instances (ZERO_REG = 0 and 1) share all inputs and are
// checked every cycle against a behavioural model, plus directed vectors and sequences.
module tb_gpr_sel_unit;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [39:0] state;
  logic [7:0]  rop_def;
  logic [7:0]  rop_al;
  logic        hold;
  logic        issue;
  gpr_idx_t    dest;
  logic        wb_valid;
  gpr_idx_t    wb_reg;

  logic [7:0]  gpr_sel_w     [2];
  logic        sel_valid_w   [2];
  logic        hazard_w      [2];
  logic        state_err_w   [2];
  logic [15:0] pending_w     [2];
  logic [4:0]  pending_cnt_w [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    gpr_sel_unit #(
      .ZERO_REG (gi[0])
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .state       (state),
      .rop_def     (rop_def),
      .rop_al      (rop_al),
      .hold        (hold),
      .issue       (issue),
      .dest        (dest),
      .wb_valid    (wb_valid),
      .wb_reg      (wb_reg),
      .gpr_sel     (gpr_sel_w[gi]),
      .sel_valid   (sel_valid_w[gi]),
      .hazard      (hazard_w[gi]),
      .state_err   (state_err_w[gi]),
      .pending     (pending_w[gi]),
      .pending_cnt (pending_cnt_w[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural reference state
  logic [7:0]  m_sel;
  logic        m_valid;
  logic        m_err;
  logic        m_haz  [2];
  logic [15:0] m_pend [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sel   = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_haz[i]  = 1'b0;
      m_pend[i] = '0;
    end
  endtask

  task automatic model_update();
    int          al_bits [6] = '{26, 28, 30, 32, 34, 36};
    logic        legal;
    logic        al;
    logic [15:0] np;
    legal = ($countones(state) == 1);
    al = 1'b0;
    for (int k = 0; k < 6; k++) if (state[al_bits[k]]) al = 1'b1;
    if (!hold) begin
      m_sel   = (legal && al) ? rop_al : rop_def;
      m_valid = legal;
      m_err   = !legal;
    end
    for (int i = 0; i < 2; i++) begin
      np = m_pend[i];
      if (wb_valid) np[wb_reg] = 1'b0;
      if (issue)    np[dest]   = 1'b1;
      if (i == 1)   np[0]      = 1'b0;
      m_pend[i] = np;
      m_haz[i]  = np[m_sel[3:0]] | np[m_sel[7:4]];
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("gpr_sel[%0d]", i),     64'(gpr_sel_w[i]),     64'(m_sel));
      chk($sformatf("sel_valid[%0d]", i),   64'(sel_valid_w[i]),   64'(m_valid));
      chk($sformatf("state_err[%0d]", i),   64'(state_err_w[i]),   64'(m_err));
      chk($sformatf("hazard[%0d]", i),      64'(hazard_w[i]),      64'(m_haz[i]));
      chk($sformatf("pending[%0d]", i),     64'(pending_w[i]),     64'(m_pend[i]));
      chk($sformatf("pending_cnt[%0d]", i), 64'(pending_cnt_w[i]), 64'($countones(m_pend[i])));
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_update();
    #1;
    $display("%-6s st=%h def=%h al=%h hold=%b iss=%b/%h wb=%b/%h -> sel=%h v=%b err=%b hz=%b/%b pend=%h/%h",
             tag, state, rop_def, rop_al, hold, issue, dest, wb_valid, wb_reg,
             gpr_sel_w[0], sel_valid_w[0], state_err_w[0], hazard_w[0], hazard_w[1],
             pending_w[0], pending_w[1]);
    check_model();
  endtask

  task automatic idle_inputs();
    hold = 1'b0; issue = 1'b0; wb_valid = 1'b0; dest = '0; wb_reg = '0;
  endtask

  typedef struct {
    logic [39:0] st;
    logic [7:0]  def;
    logic [7:0]  al;
    logic        hld;
    logic        iss;
    logic [3:0]  dst;
    logic        wbv;
    logic [3:0]  wbr;
    logic [7:0]  e_sel;
    logic        e_valid;
    logic        e_err;
    logic        e_haz;
  } vec_t;

  function automatic vec_t mk(input logic [39:0] st, input logic [7:0] def, input logic [7:0] al,
                              input logic hld, input logic iss, input logic [3:0] dst,
                              input logic wbv, input logic [3:0] wbr, input logic [7:0] e_sel,
                              input logic e_valid, input logic e_err, input logic e_haz);
    vec_t v;
    v.st = st; v.def = def; v.al = al; v.hld = hld; v.iss = iss; v.dst = dst;
    v.wbv = wbv; v.wbr = wbr; v.e_sel = e_sel; v.e_valid = e_valid; v.e_err = e_err; v.e_haz = e_haz;
    return v;
  endfunction

  vec_t vecs [12];

  initial begin
    logic [39:0] one;
    one = 40'd1;
    //              state                 def    al     hld iss dst  wb  wbr  sel    v  err hz
    vecs[0]  = mk(one << 28,              8'hAB, 8'h35, 0, 0, 4'h0, 0, 4'h0, 8'h35, 1, 0, 0);
    vecs[1]  = mk(one << 27,              8'hAB, 8'h35, 0, 0, 4'h0, 0, 4'h0, 8'hAB, 1, 0, 0);
    vecs[2]  = mk(40'd0,                  8'hAB, 8'h35, 0, 0, 4'h0, 0, 4'h0, 8'hAB, 0, 1, 0);
    vecs[3]  = mk((one<<26)|(one<<28),    8'h12, 8'h35, 0, 0, 4'h0, 0, 4'h0, 8'h12, 0, 1, 0);
    vecs[4]  = mk(one << 1,               8'h00, 8'h35, 0, 1, 4'h5, 0, 4'h0, 8'h00, 1, 0, 0);
    vecs[5]  = mk(one << 1,               8'h05, 8'h35, 0, 0, 4'h0, 0, 4'h0, 8'h05, 1, 0, 1);
    vecs[6]  = mk(40'd0,                  8'hFF, 8'h35, 1, 0, 4'h0, 0, 4'h0, 8'h05, 1, 0, 1);
    vecs[7]  = mk(40'd0,                  8'hFF, 8'h35, 1, 0, 4'h0, 1, 4'h5, 8'h05, 1, 0, 0);
    vecs[8]  = mk(one << 1,               8'h05, 8'h35, 0, 1, 4'h5, 0, 4'h0, 8'h05, 1, 0, 1);
    vecs[9]  = mk(one << 27,              8'h05, 8'h35, 0, 0, 4'h0, 1, 4'h5, 8'h05, 1, 0, 0);
    vecs[10] = mk(40'd0,                  8'h9C, 8'h35, 1, 0, 4'h0, 0, 4'h0, 8'h05, 1, 0, 0);
    vecs[11] = mk(40'd0,                  8'h9C, 8'h35, 0, 0, 4'h0, 0, 4'h0, 8'h9C, 0, 1, 0);

    rst_n = 1'b0;
    state = '0; rop_def = '0; rop_al = '0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model();
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      state = vecs[i].st; rop_def = vecs[i].def; rop_al = vecs[i].al; hold = vecs[i].hld;
      issue = vecs[i].iss; dest = vecs[i].dst; wb_valid = vecs[i].wbv; wb_reg = vecs[i].wbr;
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d gpr_sel", i),   64'(gpr_sel_w[0]),   64'(vecs[i].e_sel));
      chk($sformatf("vec%0d sel_valid", i), 64'(sel_valid_w[0]), 64'(vecs[i].e_valid));
      chk($sformatf("vec%0d state_err", i), 64'(state_err_w[0]), 64'(vecs[i].e_err));
      chk($sformatf("vec%0d hazard", i),    64'(hazard_w[0]),    64'(vecs[i].e_haz));
    end
    chk("release pending_cnt", 64'(pending_cnt_w[0]), 64'd0);

    // Simultaneous issue and writeback to an already pending register
    idle_inputs();
    state = one << 1; rop_def = 8'h00;
    issue = 1'b1; dest = 4'h7;
    step("iss7");
    wb_valid = 1'b1; wb_reg = 4'h7;
    step("iswb7");
    chk("collide pending[7]", 64'(pending_w[0][7]), 64'd1);
    chk("collide pending_cnt", 64'(pending_cnt_w[0]), 64'd1);
    idle_inputs();
    wb_valid = 1'b1; wb_reg = 4'h7;
    step("wb7");

    // R0 handling: only the ZERO_REG instance ignores writes to R0
    idle_inputs();
    issue = 1'b1; dest = 4'h0;
    step("iss0");
    chk("zreg pending[0]", 64'(pending_w[1][0]), 64'd0);
    chk("zreg hazard",     64'(hazard_w[1]),     64'd0);
    chk("noz hazard",      64'(hazard_w[0]),     64'd1);
    idle_inputs();
    wb_valid = 1'b1; wb_reg = 4'h0;
    step("wb0");
    for (int r = 0; r < 16; r++) begin
      idle_inputs();
      issue = 1'b1; dest = gpr_idx_t'(r);
      step("issall");
    end
    idle_inputs();
    step("idle");
    chk("zreg pending_cnt", 64'(pending_cnt_w[1]), 64'd15);
    chk("noz pending_cnt",  64'(pending_cnt_w[0]), 64'd16);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       state = '0;
        1:       state = {8'($urandom), 32'($urandom)};
        default: state = one << $urandom_range(0, 39);
      endcase
      rop_def  = 8'($urandom);
      rop_al   = 8'($urandom);
      hold     = ($urandom_range(0, 3) == 0);
      issue    = 1'($urandom);
      dest     = gpr_idx_t'($urandom);
      wb_valid = 1'($urandom);
      wb_reg   = gpr_idx_t'($urandom);
      step("rand");
    end

    // Drain, leave exactly three writes outstanding, then reset between edges
    for (int r = 0; r < 16; r++) begin
      idle_inputs();
      wb_valid = 1'b1; wb_reg = gpr_idx_t'(r);
      step("drain");
    end
    idle_inputs();
    state = one << 28; rop_al = 8'h39;
    issue = 1'b1; dest = 4'h3;  step("iss3");
    issue = 1'b1; dest = 4'h9;  step("iss9");
    issue = 1'b1; dest = 4'hC;  step("issC");
    idle_inputs();
    chk("pre-reset pending_cnt", 64'(pending_cnt_w[0]), 64'd3);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model();
    @(posedge clk);
    #1;
    check_model();
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
